// File: rtl/s4ga_seq.sv
// s4ga_seq: configuration sequencer for a LUT fabric.
//
// A run streams the whole configuration memory, one segment per cycle, to the
// fabric on fab_si. The memory is replayed with no gap between passes. Each
// full pass through the memory is one frame. While idle the fabric is held in
// reset.
//
// Ports
//   clk, rst                     clock and synchronous active-high reset
//   cfg_we, cfg_addr, cfg_wdata  configuration segment write port (idle only)
//   cmd_valid, cmd_ready         run command handshake
//   cmd_frames                   frames to run; 0 runs until stop or abort
//   stop                         halt at the next frame end
//   abort                        halt at the next edge
//   fab_si, fab_rst              registered segment stream and fabric reset
//   fab_out                      outputs of the last 8 fabric LUTs
//   busy, frame_done             run status; frame_done pulses after each frame
//   frame_cnt                    saturating count of completed frames
//   snap                         fab_out captured one cycle after each frame end
module s4ga_seq #(
  parameter int unsigned N    = 64,
  parameter int unsigned K    = 4,
  parameter int unsigned SI_W = 4,
  parameter int unsigned FC_W = 16,
  localparam int unsigned IDX_SEGS  = ($clog2(N) + SI_W - 1) / SI_W,
  localparam int unsigned MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W,
  localparam int unsigned LUT_SEGS  = K * IDX_SEGS + MASK_SEGS,
  localparam int unsigned TOTAL     = N * LUT_SEGS,
  localparam int unsigned AW        = $clog2(TOTAL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [SI_W-1:0] cfg_wdata,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [FC_W-1:0] cmd_frames,
  input  logic            stop,
  input  logic            abort,
  output logic [SI_W-1:0] fab_si,
  output logic            fab_rst,
  input  logic [7:0]      fab_out,
  output logic            busy,
  output logic            frame_done,
  output logic [FC_W-1:0] frame_cnt,
  output logic [7:0]      snap
);

  localparam logic [AW-1:0] LAST = AW'(TOTAL - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [FC_W-1:0]   frames_q, frames_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              frame_done_q, frame_done_d;
  logic              fab_rst_q, fab_rst_d;
  logic [SI_W-1:0]   fab_si_q, fab_si_d;
  logic [7:0]        snap_q, snap_d;

  logic [SI_W-1:0]   mem [TOTAL];

  logic [AW-1:0]     ptr_nxt;
  logic [FC_W-1:0]   cnt_inc;
  logic              frame_end;
  logic              addr_ok;

  // Addresses past the last LUT exist only when TOTAL is not a power of two.
  assign addr_ok   = (32'(cfg_addr) < TOTAL);
  assign frame_end = (ptr_q == LAST);
  assign ptr_nxt   = frame_end ? '0 : ptr_q + AW'(1);
  assign cnt_inc   = (&frame_cnt_q) ? frame_cnt_q : frame_cnt_q + FC_W'(1);

  assign cmd_ready  = (state_q == StIdle) && !cfg_we;
  assign busy       = (state_q == StRun);
  assign fab_si     = fab_si_q;
  assign fab_rst    = fab_rst_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign snap       = snap_q;

  // Config memory has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && cfg_we && (state_q == StIdle) && addr_ok) begin
      mem[cfg_addr] <= cfg_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    frames_d     = frames_q;
    frame_cnt_d  = frame_cnt_q;
    stop_pend_d  = stop_pend_q;
    frame_done_d = 1'b0;
    fab_rst_d    = fab_rst_q;
    fab_si_d     = fab_si_q;
    // frame_done_q marks the cycle after frame end: capture the fabric then.
    snap_d       = frame_done_q ? fab_out : snap_q;

    unique case (state_q)
      StIdle: begin
        fab_rst_d = 1'b1;
        fab_si_d  = '0;
        if (cmd_valid && cmd_ready) begin
          frames_d    = cmd_frames;
          frame_cnt_d = '0;
          stop_pend_d = 1'b0;
          ptr_d       = '0;
          state_d     = StRun;
          fab_rst_d   = 1'b0;
          // fab_si is registered, so load segment 0 on the accept edge.
          fab_si_d    = mem[0];
        end
      end
      StRun: begin
        if (abort) begin
          state_d   = StIdle;
          fab_rst_d = 1'b1;
          fab_si_d  = '0;
          ptr_d     = '0;
        end else begin
          if (stop) stop_pend_d = 1'b1;
          if (frame_end) begin
            frame_cnt_d  = cnt_inc;
            frame_done_d = 1'b1;
          end
          if (frame_end && (((frames_q != '0) && (cnt_inc == frames_q)) || stop_pend_q || stop))
          begin
            state_d   = StIdle;
            fab_rst_d = 1'b1;
            fab_si_d  = '0;
            ptr_d     = '0;
          end else begin
            ptr_d    = ptr_nxt;
            fab_si_d = mem[ptr_nxt];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      frames_q     <= '0;
      frame_cnt_q  <= '0;
      stop_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      fab_rst_q    <= 1'b1;
      fab_si_q     <= '0;
      snap_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      frames_q     <= frames_d;
      frame_cnt_q  <= frame_cnt_d;
      stop_pend_q  <= stop_pend_d;
      frame_done_q <= frame_done_d;
      fab_rst_q    <= fab_rst_d;
      fab_si_q     <= fab_si_d;
      snap_q       <= snap_d;
    end
  end

endmodule

// File: tb/tb_s4ga_seq.sv
// Testbench for s4ga_seq (N=16, K=4, SI_W=4 -> 128 segments per frame).
// Stimulus computes each run's expected segment stream and frame_done events
// up front and queues them; a monitor pops and compares as the DUT emits them.
// The fabric is a stub: outputs are zero while held in reset, random otherwise.
module tb_s4ga_seq;

  localparam int TOTAL = 128;
  localparam int AW    = 7;
  localparam int FC_W  = 3;
  localparam int FMAX  = 7;

  logic            clk;
  logic            rst;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [3:0]      cfg_wdata;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [FC_W-1:0] cmd_frames;
  logic            stop;
  logic            abort;
  logic [3:0]      fab_si;
  logic            fab_rst;
  logic [7:0]      fab_out;
  logic            busy;
  logic            frame_done;
  logic [FC_W-1:0] frame_cnt;
  logic [7:0]      snap;

  s4ga_seq #(.N(16), .K(4), .SI_W(4), .FC_W(FC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_frames (cmd_frames),
    .stop       (stop),
    .abort      (abort),
    .fab_si     (fab_si),
    .fab_rst    (fab_rst),
    .fab_out    (fab_out),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .snap       (snap)
  );

  typedef struct {
    int cyc;
    int cnt;
  } done_t;

  logic [3:0] ref_mem [TOTAL];
  logic [3:0] si_q [$];
  done_t      done_q [$];

  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  bit   mon_en     = 0;
  logic [7:0] snap_exp = '0;
  bit   snap_chk   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: consumes the scoreboard queues as the DUT produces output.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (snap_chk) begin
          chk("snap", 32'(snap), 32'(snap_exp));
          snap_chk = 0;
        end
        if (busy === 1'b1) begin
          chk("run_fab_rst", 32'(fab_rst), 32'd0);
          if (si_q.size() == 0) chk("si_unexpected", 32'(busy), 32'd0);
          else chk("fab_si", 32'(fab_si), 32'(si_q.pop_front()));
        end
        if (frame_done === 1'b1) begin
          if (done_q.size() == 0) begin
            chk("done_unexpected", 32'(frame_done), 32'd0);
          end else begin
            done_t d;
            d = done_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(d.cyc));
            chk("done_cnt", 32'(frame_cnt), 32'(d.cnt));
            snap_exp = fab_out;
            snap_chk = 1;
          end
        end
        if (rst === 1'b1) begin
          snap_exp = '0;
          snap_chk = 0;
        end
      end
    end
  end

  task automatic load_mem(input bit rnd);
    for (int a = 0; a < TOTAL; a++) begin
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_addr  = AW'(a);
      cfg_wdata = rnd ? 4'($urandom) : 4'(a);
      ref_mem[a] = cfg_wdata;
      if (a == 5) begin
        #1;
        chk("cmd_ready_during_write", 32'(cmd_ready), 32'd0);
      end
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One run. a is the abort (or reset when by_rst) cycle, s the stop cycle;
  // 0 means none. Cycle 0 is the accept cycle.
  task automatic do_run(input int f, input int s, input int a, input bit by_rst);
    int acc;
    int e;
    int cnt;
    int c;
    bit fin;
    @(negedge clk);
    acc = cyc;
    cnt = 0;
    e   = 0;
    c   = 1;
    fin = 0;
    while (!fin) begin
      si_q.push_back(ref_mem[(c - 1) % TOTAL]);
      if (a != 0 && c == a) begin
        fin = 1;
        e   = c;
        if (by_rst) cnt = 0;
      end else if (c % TOTAL == 0) begin
        cnt = (cnt == FMAX) ? FMAX : cnt + 1;
        done_q.push_back('{cyc: acc + c + 1, cnt: cnt});
        if ((f != 0 && cnt == f) || (s != 0 && s <= c)) begin
          fin = 1;
          e   = c;
        end
      end
      c++;
    end
    cmd_valid  = 1'b1;
    cmd_frames = FC_W'(f);
    for (int k = 1; k <= e + 2; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      stop      = (k == s);
      abort     = !by_rst && (k == a);
      rst       = by_rst && (k == a);
      cfg_we    = (k == 20) && (20 <= e);
      if (cfg_we) begin
        cfg_addr  = AW'($urandom);
        cfg_wdata = ~ref_mem[cfg_addr];
      end
      fab_out = fab_rst ? 8'h00 : 8'($urandom);
    end
    stop   = 1'b0;
    abort  = 1'b0;
    rst    = 1'b0;
    cfg_we = 1'b0;
    #1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_fab_rst", 32'(fab_rst), 32'd1);
    chk("end_fab_si", 32'(fab_si), 32'd0);
    chk("end_frame_cnt", 32'(frame_cnt), 32'(cnt));
    chk("end_si_left", 32'(si_q.size()), 32'd0);
    chk("end_done_left", 32'(done_q.size()), 32'd0);
    if (by_rst) chk("snap_after_rst", 32'(snap), 32'd0);
    si_q.delete();
    done_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    cmd_valid  = 1'b0;
    cmd_frames = '0;
    stop       = 1'b0;
    abort      = 1'b0;
    fab_out    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_fab_rst", 32'(fab_rst), 32'd1);
    chk("rst_fab_si", 32'(fab_si), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_snap", 32'(snap), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    mon_en = 1;

    load_mem(0);
    do_run(1, 0, 0, 0);
    // A stop pulse while idle must not shorten the next run.
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    do_run(3, 0, 0, 0);
    do_run(0, 200, 0, 0);
    do_run(0, 128, 0, 0);
    do_run(1, 0, 50, 0);
    do_run(1, 0, 50, 1);
    do_run(1, 0, 0, 0);
    load_mem(1);
    // Nine frames with a 3-bit counter: frame_cnt must saturate at 7.
    do_run(0, 9 * TOTAL - 5, 0, 0);
    do_run(FMAX, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      int f;
      int s;
      int a;
      f = $urandom_range(0, FMAX);
      if (f == 0) s = $urandom_range(1, 700);
      else s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 900) : 0;
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 500) : 0;
      do_run(f, s, a, 0);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s4ga_seq.md
S4GA_SEQ -- requirements
Module: s4ga_seq

Interface
REQ-001 Parameters SHALL be: N 64 (fabric LUT count); K 4 (LUT inputs); SI_W 4 (segment width); FC_W 16 (frame counter width).
REQ-002 Derived constants SHALL be: IDX_SEGS=ceil(clog2(N)/SI_W); MASK_SEGS=ceil(2**K/SI_W); LUT_SEGS=K*IDX_SEGS+MASK_SEGS; TOTAL=N*LUT_SEGS; AW=clog2(TOTAL).
REQ-003 clk in 1: the only clock; also the fabric clock.
REQ-004 rst in 1: reset, synchronous, active-high.
REQ-005 cfg_we in 1, cfg_addr in AW, cfg_wdata in SI_W: config segment write port.
REQ-006 cmd_valid in 1, cmd_ready out 1, cmd_frames in FC_W: run command, where 0 means run until stop or abort.
REQ-007 stop in 1: graceful halt at the next frame end; abort in 1: immediate halt.
REQ-008 fab_si out SI_W, fab_rst out 1: fabric segment stream and fabric reset, both registered.
REQ-009 fab_out in 8: fabric LUT outputs (last 8 LUTs).
REQ-010 busy out 1, frame_done out 1, frame_cnt out FC_W, snap out 8: status outputs.

Function
REQ-011 Config memory SHALL be TOTAL x SI_W, addressed lut*LUT_SEGS+seg, ordered as: K index fields of IDX_SEGS segments each, then the mask in MASK_SEGS segments, most-significant segment first.
REQ-012 A write (cfg_we=1) SHALL take effect only in IDLE; writes in RUN SHALL be ignored; addresses >= TOTAL SHALL be ignored.
REQ-013 FSM states SHALL be IDLE and RUN.
REQ-014 In IDLE, the outputs SHALL be: fab_rst=1, fab_si=0, busy=0.
REQ-015 cmd_ready SHALL be 1 only in IDLE with cfg_we=0.
REQ-016 On accept (cmd_valid & cmd_ready), the block SHALL: latch cmd_frames; clear frame_cnt and any pending stop; clear the segment pointer ptr to 0; enter RUN.
REQ-017 In RUN, each cycle SHALL present fab_rst=0, fab_si=mem[ptr], busy=1; ptr increments by 1 and wraps TOTAL-1 -> 0 with no gap cycle.
REQ-018 First segment latency: the first RUN cycle after the accept edge SHALL present mem[0].
REQ-019 Frame end is the cycle T presenting ptr=TOTAL-1. At the edge ending T, frame_cnt SHALL increment, saturating at all-ones. frame_done SHALL pulse for exactly one cycle in T+1.
REQ-020 snap SHALL load fab_out at the edge ending T+1 and hold that value until the next load; reset clears it to 0.
REQ-021 At the edge ending T, the FSM SHALL go to IDLE if any of these holds: cmd_frames!=0 and the new frame_cnt==cmd_frames; stop is pending; stop=1 in cycle T. Otherwise it SHALL stay in RUN. In that IDLE case, fab_rst=1 from T+1.
REQ-022 A stop pulse SHALL set the pending stop; stop in IDLE SHALL be ignored.
REQ-023 abort=1 in RUN SHALL force IDLE at the next edge: partial frame discarded, no frame_done, frame_cnt unchanged. abort SHALL have priority over stop and frame end.
REQ-024 frame_cnt SHALL hold its value in IDLE until the next accept.
REQ-025 While IDLE, the fabric is held in reset, which clears its LUT state; each run SHALL therefore start from zeroed fabric outputs.

Reset
REQ-026 rst SHALL have priority over all inputs and SHALL force: IDLE, ptr=0, frame_cnt=0, snap=0, frame_done=0, stop pending=0, fab_rst=1, fab_si=0.
REQ-027 rst SHALL NOT clear the config memory; rst mid-RUN SHALL abort with no frame_done.

Verification (N=16, K=4, SI_W=4: LUT_SEGS=8, TOTAL=128; accept at the edge ending cycle 0)
REQ-028 Reset: rst high 1 cycle -> fab_rst=1, fab_si=0, busy=0, cmd_ready=1, frame_cnt=0, snap=0.
REQ-029 Single frame: mem[a]=a[3:0], cmd_frames=1 -> fab_si=0,1,..,15,0,.. on cycles 1..128; frame_done only in cycle 129; fab_rst=1 and busy=0 from 129; frame_cnt=1.
REQ-030 Multi-frame: cmd_frames=3 -> frame_done in cycles 129, 257, 385; fab_rst=0 continuously over cycles 1..384; frame_cnt=3.
REQ-031 Stop: cmd_frames=0, stop pulsed in cycle 200 -> frame_done in 129 and 257, IDLE from 257, frame_cnt=2. Stop pulsed in cycle 128 instead -> IDLE from 129.
REQ-032 Abort/reset: abort (or rst) in cycle 50 -> fab_rst=1 in 51, no frame_done, frame_cnt=0; a write attempted in cycle 20 leaves memory unchanged.
REQ-033 Co-sim with the fabric, all masks 16'hFFFF, cmd_frames=1 -> snap=8'hFF from cycle 130; all masks 0 -> snap=8'h00.
